// File: rtl/tdm_onetofour_demux.sv
// Time-division 1-to-4 demultiplexer: rebuilds four parallel lanes from a slot-serial stream.
// Optional framing-error counter on ERRC is enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_onetofour_demux #(
   parameter int unsigned W = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           E,
   input  logic [W-1:0]   D,
   input  logic           F,
   output logic [4*W-1:0] Y,
   output logic           V,
   output logic [1:0]     S,
   output logic           L,
   output logic           ERR,
   output logic [7:0]     ERRC
);

   localparam logic [0:0] HUNT = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [1:0]     slot_q, slot_d;
   logic [W-1:0]   sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
   logic [4*W-1:0] y_q, y_d;
   logic           v_q, v_d;
   logic           err_q, err_d;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      y_d     = y_q;
      v_d     = 1'b0;
      err_d   = 1'b0;
      if (E) begin
         if (state_q == HUNT) begin
            slot_d = 2'd0;
            if (F) begin
               sh0_d   = D;
               slot_d  = 2'd1;
               state_d = LOCK;
            end
         end else if (slot_q == 2'd0) begin
            if (F) begin
               sh0_d  = D;
               slot_d = 2'd1;
            end else begin
               // Missing sync: lose lock, Y keeps the last good frame.
               err_d   = 1'b1;
               slot_d  = 2'd0;
               state_d = HUNT;
            end
         end else if (F) begin
            // Early sync: drop the partial frame and restart at slot 0 with this sample.
            err_d  = 1'b1;
            sh0_d  = D;
            slot_d = 2'd1;
         end else begin
            case (slot_q)
               2'd1: begin
                  sh1_d  = D;
                  slot_d = 2'd2;
               end
               2'd2: begin
                  sh2_d  = D;
                  slot_d = 2'd3;
               end
               default: begin
                  y_d    = {D, sh2_q, sh1_q, sh0_q};
                  v_d    = 1'b1;
                  slot_d = 2'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         slot_q  <= 2'd0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         y_q     <= '0;
         v_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         y_q     <= y_d;
         v_q     <= v_d;
         err_q   <= err_d;
      end
   end

`ifdef TDM_DEMUX_ERRCNT_EN
   logic [7:0] errc_q;

   // Saturating count, incremented on the same edge that raises ERR.
   always_ff @(posedge clk) begin
      if (rst) begin
         errc_q <= 8'd0;
      end else if (err_d && (errc_q != 8'hFF)) begin
         errc_q <= errc_q + 8'd1;
      end
   end

   assign ERRC = errc_q;
`else
   assign ERRC = 8'd0;
`endif

   assign Y   = y_q;
   assign V   = v_q;
   assign S   = slot_q;
   assign L   = (state_q == LOCK);
   assign ERR = err_q;

endmodule

// File: tb/tb_tdm_onetofour_demux.sv
// Directed bench for tdm_onetofour_demux with W=1; expected values are hand-computed.
// ERRC expectations follow TDM_DEMUX_ERRCNT_EN when the bench is built with it.
module tb_tdm_onetofour_demux;

   logic       clk = 1'b0;
   logic       rst;
   logic       E;
   logic [0:0] D;
   logic       F;
   logic [3:0] Y;
   logic       V;
   logic [1:0] S;
   logic       L;
   logic       ERR;
   logic [7:0] ERRC;

   int tests = 0;
   int fails = 0;
   int nerr  = 0;

   tdm_onetofour_demux #(.W(1)) dut (
      .clk  (clk),
      .rst  (rst),
      .E    (E),
      .D    (D),
      .F    (F),
      .Y    (Y),
      .V    (V),
      .S    (S),
      .L    (L),
      .ERR  (ERR),
      .ERRC (ERRC)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] errc_exp(input int n);
`ifdef TDM_DEMUX_ERRCNT_EN
      return (n > 255) ? 32'd255 : 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one sample, clock it, then settle past the edge.
   task automatic cyc(input logic e, input logic d, input logic f);
      E = e;
      D = d;
      F = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      E = 1'b1; D = 1'b0; F = 1'b0;
      for (int i = 0; i < 2; i++) begin
         D = 1'($urandom);
         F = 1'($urandom);
         @(posedge clk);
         #1;
      end
      chk("rst_Y", 32'(Y), 0);
      chk("rst_V", 32'(V), 0);
      chk("rst_S", 32'(S), 0);
      chk("rst_L", 32'(L), 0);
      chk("rst_ERR", 32'(ERR), 0);
      chk("rst_ERRC", 32'(ERRC), 0);
      rst = 1'b0;

      // HUNT discards unsynced data
      cyc(1, 1, 0);
      chk("hunt_L", 32'(L), 0);
      chk("hunt_S", 32'(S), 0);

      // Single frame 1,0,0,1
      cyc(1, 1, 1);
      chk("sf_L", 32'(L), 1);
      chk("sf_S1", 32'(S), 1);
      cyc(1, 0, 0);
      chk("sf_S2", 32'(S), 2);
      cyc(1, 0, 0);
      chk("sf_S3", 32'(S), 3);
      chk("sf_V_early", 32'(V), 0);
      cyc(1, 1, 0);
      chk("sf_V", 32'(V), 1);
      chk("sf_Y", 32'(Y), 4'b1001);
      chk("sf_S0", 32'(S), 0);
      cyc(0, 0, 0);
      chk("sf_V_once", 32'(V), 0);
      chk("sf_Y_hold", 32'(Y), 4'b1001);

      // Stall between slots 1 and 2
      cyc(1, 1, 1);
      cyc(1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1);
         chk("stall_S", 32'(S), 2);
         chk("stall_V", 32'(V), 0);
         chk("stall_ERR", 32'(ERR), 0);
      end
      cyc(1, 0, 0);
      chk("stall_S3", 32'(S), 3);
      cyc(1, 1, 0);
      chk("stall_V", 32'(V), 1);
      chk("stall_Y", 32'(Y), 4'b1001);

      // Early sync on slot 2
      cyc(1, 1, 1);
      cyc(1, 1, 0);
      cyc(1, 0, 1);
      nerr++;
      chk("es_ERR", 32'(ERR), 1);
      chk("es_V", 32'(V), 0);
      chk("es_S", 32'(S), 1);
      chk("es_L", 32'(L), 1);
      cyc(1, 1, 0);
      chk("es_ERR_once", 32'(ERR), 0);
      cyc(1, 1, 0);
      chk("es_V_none", 32'(V), 0);
      cyc(1, 0, 0);
      chk("es_V", 32'(V), 1);
      chk("es_Y", 32'(Y), 4'b0110);
      chk("es_ERRC", 32'(ERRC), errc_exp(nerr));

      // Missing sync at slot 0
      cyc(1, 1, 0);
      nerr++;
      chk("ms_ERR", 32'(ERR), 1);
      chk("ms_L", 32'(L), 0);
      chk("ms_S", 32'(S), 0);
      chk("ms_Y_hold", 32'(Y), 4'b0110);
      cyc(1, 0, 1);
      chk("ms_relock", 32'(L), 1);
      chk("ms_ERR_once", 32'(ERR), 0);
      cyc(1, 1, 0);
      cyc(1, 0, 0);
      cyc(1, 1, 0);
      chk("ms_V", 32'(V), 1);
      chk("ms_Y", 32'(Y), 4'b1010);
      chk("ms_ERRC", 32'(ERRC), errc_exp(nerr));

      // 300 missing-sync errors: counter saturates (or stays 0 without the counter)
      for (int i = 0; i < 300; i++) begin
         cyc(1, 1, 1);
         cyc(1, 0, 0);
         cyc(1, 0, 0);
         cyc(1, 0, 0);
         cyc(1, 0, 0);
         nerr++;
         if (i == 100) chk("sat_mid", 32'(ERRC), errc_exp(nerr));
      end
      chk("sat_ERR", 32'(ERR), 1);
      chk("sat_ERRC", 32'(ERRC), errc_exp(nerr));
      chk("sat_Y", 32'(Y), 4'b0001);
      cyc(1, 0, 0);
      chk("sat_hold", 32'(ERRC), errc_exp(nerr));

      // Reset mid-frame beats a concurrent sync
      cyc(1, 1, 1);
      cyc(1, 1, 0);
      rst = 1'b1;
      cyc(1, 1, 1);
      rst = 1'b0;
      chk("rmf_Y", 32'(Y), 0);
      chk("rmf_S", 32'(S), 0);
      chk("rmf_L", 32'(L), 0);
      chk("rmf_ERRC", 32'(ERRC), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
